// File: rtl/round_scorer_pkg.sv
// Shared types and constants for the round scorer: FSM states, score ceiling,
// and code width.
package round_scorer_pkg;

    localparam int          CODE_W    = 4;
    localparam logic [6:0]  SCORE_MAX = 7'd99;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CLEAR       = 3'd1,
        WAIT_TARGET = 3'd2,
        WAIT_GUESS  = 3'd3,
        DONE        = 3'd4
    } state_t;

endpackage

// File: rtl/round_scorer_if.sv
// Player/score-counter signal bundle for round_scorer. The master side drives
// the player inputs; the slave side is the scorer.
interface round_scorer_if;
    import round_scorer_pkg::*;

    logic              Start;
    logic [CODE_W-1:0] Target;
    logic              Target_Valid;
    logic [CODE_W-1:0] Guess;
    logic              Guess_Valid;
    logic              Score_Reconfig;
    logic              Score_Enable;
    logic              Increment;
    logic [1:0]        Misses;
    logic              Round_Active;
    logic              Game_Over;

    modport master (
        output Start, Target, Target_Valid, Guess, Guess_Valid,
        input  Score_Reconfig, Score_Enable, Increment, Misses, Round_Active, Game_Over
    );

    modport slave (
        input  Start, Target, Target_Valid, Guess, Guess_Valid,
        output Score_Reconfig, Score_Enable, Increment, Misses, Round_Active, Game_Over
    );

endinterface

// File: rtl/round_timer.sv
// 16-bit round down-counter: load wins over counting, holds at zero, and flags
// expiry while enabled at zero.
module round_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_en,
    output logic        o_expire
);

    logic [15:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/round_scorer.sv
// Game-round controller feeding a two-digit score counter: latches a target,
// times each round, judges guesses, and stops after MAX_MISSES misses.
module round_scorer
    import round_scorer_pkg::*;
#(
    parameter logic [15:0] ROUND_CYCLES = 16'd50000,
    parameter int          MAX_MISSES   = 3
) (
    input  logic           clk,
    input  logic           rst,
    round_scorer_if.slave  bus
);

    localparam logic [1:0] MAX_MISS_L = 2'(MAX_MISSES);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_misses;
    logic [1:0]        w_next_misses;
    logic [6:0]        r_hits;
    logic [6:0]        w_next_hits;
    logic [CODE_W-1:0] r_target;
    logic              w_target_accept;
    logic              w_hit;
    logic              w_miss;
    logic              w_inc;
    logic              w_expire;

    logic r_reconfig;
    logic r_enable;
    logic r_increment;
    logic r_active;
    logic r_game_over;

    round_timer u_round_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_target_accept),
        .i_load_val (ROUND_CYCLES - 16'd1),
        .i_en       (r_state == WAIT_GUESS),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state    = r_state;
        w_next_misses   = r_misses;
        w_next_hits     = r_hits;
        w_target_accept = 1'b0;
        w_hit           = 1'b0;
        w_miss          = 1'b0;
        w_inc           = 1'b0;

        if (bus.Start) begin
            // Restart wins over anything else happening this cycle.
            w_next_state  = CLEAR;
            w_next_misses = '0;
            w_next_hits   = '0;
        end else begin
            case (r_state)
                IDLE:        ;
                CLEAR:       w_next_state = WAIT_TARGET;
                WAIT_TARGET: begin
                    if (bus.Target_Valid) begin
                        w_target_accept = 1'b1;
                        w_next_state    = WAIT_GUESS;
                    end
                end
                WAIT_GUESS: begin
                    // A guess on the last timer cycle is judged; the timeout is dropped.
                    if (bus.Guess_Valid) begin
                        if (bus.Guess == r_target) w_hit  = 1'b1;
                        else                       w_miss = 1'b1;
                    end else if (w_expire) begin
                        w_miss = 1'b1;
                    end

                    if (w_hit) begin
                        w_next_state = WAIT_TARGET;
                        if (r_hits < SCORE_MAX) begin
                            w_next_hits = r_hits + 7'd1;
                            w_inc       = 1'b1;
                        end
                    end

                    if (w_miss) begin
                        w_next_misses = r_misses + 2'd1;
                        w_next_state  = (w_next_misses == MAX_MISS_L) ? DONE : WAIT_TARGET;
                    end
                end
                DONE:        ;
                default:     w_next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misses    <= '0;
            r_hits      <= '0;
            r_target    <= '0;
            r_reconfig  <= 1'b0;
            r_enable    <= 1'b0;
            r_increment <= 1'b0;
            r_active    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_misses    <= w_next_misses;
            r_hits      <= w_next_hits;
            if (w_target_accept) r_target <= bus.Target;
            r_reconfig  <= (w_next_state == CLEAR);
            r_enable    <= (w_next_state == WAIT_TARGET) || (w_next_state == WAIT_GUESS);
            r_increment <= w_inc;
            r_active    <= (w_next_state == WAIT_GUESS);
            r_game_over <= (w_next_state == DONE);
        end
    end

    assign bus.Score_Reconfig = r_reconfig;
    assign bus.Score_Enable   = r_enable;
    assign bus.Increment      = r_increment;
    assign bus.Misses         = r_misses;
    assign bus.Round_Active   = r_active;
    assign bus.Game_Over      = r_game_over;

endmodule
